power_switch_ctrl: RTL and testbench

POWER_SWITCH_CTRL -- requirements
Module: power_switch_ctrl

---
 rtl/power_switch_ctrl_if.sv | 32 +++
 rtl/power_switch_ctrl.sv | 159 +++++++++++++++
 tb/tb_power_switch_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/power_switch_ctrl_if.sv
// ============================================================================
// power_switch_ctrl_if : request/config/status bundle of the power-switch controller
// Rev 1.0
// ============================================================================
`default_nettype none

interface power_switch_ctrl_if #(
  parameter int SEGMENTS = 4,
  parameter int DLY_W    = 8
);
  logic                req_on;
  logic [DLY_W-1:0]    step_dly;
  logic [DLY_W-1:0]    settle_dly;
  logic [SEGMENTS-1:0] gate;
  logic                iso_en;
  logic                dom_rst;
  logic                pwr_good;
  logic                busy;

  // master: the power-management agent issuing requests; slave: the controller
  modport master (
    output req_on, step_dly, settle_dly,
    input  gate, iso_en, dom_rst, pwr_good, busy
  );

  modport slave (
    input  req_on, step_dly, settle_dly,
    output gate, iso_en, dom_rst, pwr_good, busy
  );
endinterface

`default_nettype wire

// File: rtl/power_switch_ctrl.sv
// ============================================================================
// power_switch_ctrl : staged power-switch sequencer with isolation and domain reset
// Rev 1.0
// ============================================================================
`default_nettype none

module power_switch_ctrl #(
  parameter int SEGMENTS = 4,
  parameter int DLY_W    = 8
) (
  input  wire logic          wb_clk_i,
  input  wire logic          wb_rst_i,
  power_switch_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_SETTLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_ON        = 3'd4,
    S_ISOLATE   = 3'd5,
    S_RAMP_DOWN = 3'd6
  } state_t;

  localparam logic [SEGMENTS-1:0] C_GATE_FIRST = {{(SEGMENTS-1){1'b0}}, 1'b1};
  localparam logic [DLY_W-1:0]    C_CNT_ONE    = {{(DLY_W-1){1'b0}}, 1'b1};

  state_t              state_q;
  logic [DLY_W-1:0]    cnt_q;
  logic [DLY_W-1:0]    step_q;
  logic [DLY_W-1:0]    settle_q;
  logic [SEGMENTS-1:0] gate_q;
  logic                iso_q;
  logic                drst_q;
  logic                pgood_q;
  logic                busy_q;

  logic w_last_up;
  logic w_last_down;
  logic w_step_done;
  logic w_settle_done;

  // Thermometer code: the next set/clear completes the ramp when these hold
  assign w_last_up     = &gate_q[SEGMENTS-2:0];
  assign w_last_down   = ~gate_q[1];
  assign w_step_done   = (cnt_q == step_q);
  assign w_settle_done = (cnt_q == settle_q);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= S_OFF;
      cnt_q    <= '0;
      step_q   <= '0;
      settle_q <= '0;
      gate_q   <= '0;
      iso_q    <= 1'b1;
      drst_q   <= 1'b1;
      pgood_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_OFF: begin
          if (bus.req_on) begin
            state_q  <= S_RAMP_UP;
            gate_q   <= C_GATE_FIRST;
            cnt_q    <= '0;
            step_q   <= bus.step_dly;
            settle_q <= bus.settle_dly;
            busy_q   <= 1'b1;
          end
        end
        S_RAMP_UP: begin
          if (!bus.req_on) begin
            state_q <= S_ISOLATE;
          end else if (w_step_done) begin
            cnt_q  <= '0;
            gate_q <= {gate_q[SEGMENTS-2:0], 1'b1};
            if (w_last_up) state_q <= S_SETTLE;
          end else begin
            cnt_q <= cnt_q + C_CNT_ONE;
          end
        end
        S_SETTLE: begin
          if (!bus.req_on) begin
            state_q <= S_ISOLATE;
          end else if (w_settle_done) begin
            state_q <= S_RELEASE;
            iso_q   <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + C_CNT_ONE;
          end
        end
        S_RELEASE: begin
          if (!bus.req_on) begin
            state_q <= S_ISOLATE;
            iso_q   <= 1'b1;
          end else begin
            state_q <= S_ON;
            drst_q  <= 1'b0;
            pgood_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        S_ON: begin
          if (!bus.req_on) begin
            state_q <= S_ISOLATE;
            iso_q   <= 1'b1;
            drst_q  <= 1'b1;
            pgood_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_ISOLATE: begin
          gate_q <= gate_q >> 1;
          cnt_q  <= '0;
          if (w_last_down) begin
            state_q <= S_OFF;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_RAMP_DOWN;
          end
        end
        S_RAMP_DOWN: begin
          // Requests are deliberately ignored until the domain is fully off
          if (w_step_done) begin
            cnt_q  <= '0;
            gate_q <= gate_q >> 1;
            if (w_last_down) begin
              state_q <= S_OFF;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + C_CNT_ONE;
          end
        end
        default: begin
          state_q <= S_OFF;
          cnt_q   <= '0;
          gate_q  <= '0;
          iso_q   <= 1'b1;
          drst_q  <= 1'b1;
          pgood_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gate     = gate_q;
  assign bus.iso_en   = iso_q;
  assign bus.dom_rst  = drst_q;
  assign bus.pwr_good = pgood_q;
  assign bus.busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_power_switch_ctrl.sv
// ============================================================================
// tb_power_switch_ctrl : directed + randomized checks against a timestamp-based reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_power_switch_ctrl;
  localparam int SEGMENTS = 4;
  localparam int DLY_W    = 8;

  localparam int P_OFF = 0, P_UP = 1, P_SETTLE = 2, P_REL = 3, P_ON = 4, P_ISO = 5, P_DOWN = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  power_switch_ctrl_if #(.SEGMENTS(SEGMENTS), .DLY_W(DLY_W)) bus ();

  power_switch_ctrl #(.SEGMENTS(SEGMENTS), .DLY_W(DLY_W)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  int     errors = 0;
  int     checks = 0;
  longint now    = 0;

  // Reference model: segment count plus absolute-cycle deadlines
  int     m_phase = P_OFF;
  int     m_segs  = 0;
  longint m_deadline = 0;
  int     m_d = 0;
  int     m_t = 0;
  logic [SEGMENTS-1:0] prev_gate = '0;
  logic   rst_seen = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, now);
    end
  endtask

  task automatic model_step();
    rst_seen = rst;
    if (rst) begin
      m_phase = P_OFF;
      m_segs  = 0;
    end else begin
      case (m_phase)
        P_OFF: if (bus.req_on) begin
          m_d = int'(bus.step_dly);
          m_t = int'(bus.settle_dly);
          m_segs = 1;
          m_deadline = now + m_d + 1;
          m_phase = P_UP;
        end
        P_UP: begin
          if (!bus.req_on) m_phase = P_ISO;
          else if (now == m_deadline) begin
            m_segs++;
            if (m_segs == SEGMENTS) begin
              m_phase = P_SETTLE;
              m_deadline = now + m_t + 1;
            end else begin
              m_deadline = now + m_d + 1;
            end
          end
        end
        P_SETTLE: begin
          if (!bus.req_on) m_phase = P_ISO;
          else if (now == m_deadline) m_phase = P_REL;
        end
        P_REL: m_phase = bus.req_on ? P_ON : P_ISO;
        P_ON:  if (!bus.req_on) m_phase = P_ISO;
        P_ISO: begin
          m_segs--;
          m_deadline = now + m_d + 1;
          m_phase = (m_segs == 0) ? P_OFF : P_DOWN;
        end
        P_DOWN: if (now == m_deadline) begin
          m_segs--;
          m_deadline = now + m_d + 1;
          if (m_segs == 0) m_phase = P_OFF;
        end
        default: m_phase = P_OFF;
      endcase
    end
  endtask

  task automatic tick();
    logic [SEGMENTS-1:0] g;
    logic [SEGMENTS-1:0] g1;
    @(posedge clk);
    now++;
    model_step();
    #1;
    g  = bus.gate;
    g1 = g + 1'b1;
    chk("gate",   32'(g),               32'((1 << m_segs) - 1));
    chk("iso_en", 32'(bus.iso_en),      32'(!(m_phase == P_REL || m_phase == P_ON)));
    chk("dom_rst", 32'(bus.dom_rst),    32'(m_phase != P_ON));
    chk("pwr_good", 32'(bus.pwr_good),  32'(m_phase == P_ON));
    chk("busy",   32'(bus.busy),        32'(m_phase != P_OFF && m_phase != P_ON));
    chk("thermo", 32'((g & g1) == '0), 32'd1);
    if (!rst_seen) chk("onebit", 32'($countones(g ^ prev_gate) <= 1), 32'd1);
    prev_gate = g;
  endtask

  task automatic wait_off(input string tag);
    int n;
    n = 0;
    while ((bus.busy || bus.pwr_good) && n < 2000) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < 2000), 32'd1);
  endtask

  initial begin
    bus.req_on     = 1'b0;
    bus.step_dly   = '0;
    bus.settle_dly = '0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_gate", 32'(bus.gate), 32'h0);
    chk("rst_iso",  32'(bus.iso_en), 32'h1);
    rst = 1'b0;
    tick();

    // Nominal power-up, D=3 T=5; a mid-ramp step_dly change must be ignored
    bus.step_dly = 8'd3; bus.settle_dly = 8'd5; bus.req_on = 1'b1;
    for (int i = 0; i <= 19; i++) begin
      tick();
      if (i == 2) bus.step_dly = 8'd0;
      if (i == 0)  chk("up_g0",  32'(bus.gate), 32'h1);
      if (i == 3)  chk("up_g3",  32'(bus.gate), 32'h1);
      if (i == 4)  chk("up_g4",  32'(bus.gate), 32'h3);
      if (i == 8)  chk("up_g8",  32'(bus.gate), 32'h7);
      if (i == 12) chk("up_g12", 32'(bus.gate), 32'hf);
      if (i == 17) chk("up_iso17", 32'(bus.iso_en), 32'h1);
      if (i == 18) chk("up_iso18", 32'(bus.iso_en), 32'h0);
      if (i == 18) chk("up_pg18",  32'(bus.pwr_good), 32'h0);
      if (i == 19) chk("up_pg19",  32'(bus.pwr_good), 32'h1);
      if (i == 19) chk("up_rst19", 32'(bus.dom_rst), 32'h0);
      if (i <= 18) chk("up_busy",  32'(bus.busy), 32'h1);
      if (i == 19) chk("up_busy19", 32'(bus.busy), 32'h0);
    end

    // Power-down from ON
    bus.req_on = 1'b0;
    for (int j = 0; j <= 13; j++) begin
      tick();
      if (j == 0)  chk("dn_iso0", 32'({bus.iso_en, bus.dom_rst, bus.pwr_good}), 32'h6);
      if (j == 0)  chk("dn_g0",  32'(bus.gate), 32'hf);
      if (j == 1)  chk("dn_g1",  32'(bus.gate), 32'h7);
      if (j == 5)  chk("dn_g5",  32'(bus.gate), 32'h3);
      if (j == 9)  chk("dn_g9",  32'(bus.gate), 32'h1);
      if (j == 12) chk("dn_busy12", 32'(bus.busy), 32'h1);
      if (j == 13) chk("dn_g13", 32'(bus.gate), 32'h0);
      if (j == 13) chk("dn_busy13", 32'(bus.busy), 32'h0);
    end

    // Abort during ramp-up at gate=0011
    bus.step_dly = 8'd3; bus.settle_dly = 8'd5; bus.req_on = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      tick();
      if (i == 4) bus.req_on = 1'b0;
      if (i == 5)  chk("ab_g5",  32'(bus.gate), 32'h3);
      if (i == 6)  chk("ab_g6",  32'(bus.gate), 32'h1);
      if (i == 9)  chk("ab_g9",  32'(bus.gate), 32'h1);
      if (i == 10) chk("ab_g10", 32'(bus.gate), 32'h0);
      chk("ab_iso", 32'(bus.iso_en), 32'h1);
      chk("ab_pg",  32'(bus.pwr_good), 32'h0);
    end

    // Re-request during ramp-down completes the ramp-down first
    bus.step_dly = 8'd1; bus.settle_dly = 8'd0; bus.req_on = 1'b1;
    begin
      int n;
      n = 0;
      while (!bus.pwr_good && n < 100) begin tick(); n++; end
      chk("re_reach_on", 32'(bus.pwr_good), 32'h1);
    end
    bus.req_on = 1'b0;
    tick();
    tick();
    chk("re_g1", 32'(bus.gate), 32'h7);
    bus.req_on = 1'b1;
    begin
      int n;
      n = 0;
      while (bus.gate != '0 && n < 100) begin tick(); n++; end
      chk("re_drain", 32'(bus.gate), 32'h0);
      chk("re_drain_t", 32'(n), 32'd6);
    end
    tick();
    chk("re_restart", 32'(bus.gate), 32'h1);
    bus.req_on = 1'b0;
    wait_off("re_off_timeout");

    // Minimum delays D=0 T=0
    bus.step_dly = 8'd0; bus.settle_dly = 8'd0; bus.req_on = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      tick();
      if (i == 1) bus.step_dly = 8'd7;
      if (i == 0) chk("min_g0", 32'(bus.gate), 32'h1);
      if (i == 1) chk("min_g1", 32'(bus.gate), 32'h3);
      if (i == 2) chk("min_g2", 32'(bus.gate), 32'h7);
      if (i == 3) chk("min_g3", 32'(bus.gate), 32'hf);
      if (i == 3) chk("min_iso3", 32'(bus.iso_en), 32'h1);
      if (i == 4) chk("min_iso4", 32'(bus.iso_en), 32'h0);
      if (i == 4) chk("min_pg4", 32'(bus.pwr_good), 32'h0);
      if (i == 5) chk("min_pg5", 32'(bus.pwr_good), 32'h1);
    end
    bus.req_on = 1'b0;
    wait_off("min_off_timeout");

    // Abrupt reset at gate=0111
    bus.step_dly = 8'd2; bus.settle_dly = 8'd1; bus.req_on = 1'b1;
    begin
      int n;
      n = 0;
      while (bus.gate != 4'h7 && n < 100) begin tick(); n++; end
      chk("rs_reach", 32'(bus.gate), 32'h7);
    end
    rst = 1'b1;
    tick();
    chk("rs_out", 32'({bus.gate, bus.iso_en, bus.dom_rst, bus.pwr_good, bus.busy}), 32'b0000_1_1_0_0);
    rst = 1'b0;
    bus.req_on = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("rs_idle", 32'(bus.gate), 32'h0);

    // Maximal step delay: 256 cycles per step
    bus.step_dly = 8'hff; bus.settle_dly = 8'd3; bus.req_on = 1'b1;
    for (int i = 0; i <= 260; i++) begin
      tick();
      if (i == 255) chk("max_g255", 32'(bus.gate), 32'h1);
      if (i == 256) chk("max_g256", 32'(bus.gate), 32'h3);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_on = 1'b0;
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 24) == 0) bus.req_on = ~bus.req_on;
      bus.step_dly   = DLY_W'($urandom_range(0, 3));
      bus.settle_dly = DLY_W'($urandom_range(0, 4));
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
